// File: rtl/dmem_arb_pkg.sv
// Shared sizes and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Default sizes shared with the memory and pipeline.
    localparam int unsigned SIZE_ADDR = 8;
    localparam int unsigned SIZE_DATA = 16;

    // Requester identifiers carried with an outstanding read.
    localparam logic ARB_ID_PIPE = 1'b0;
    localparam logic ARB_ID_HOST = 1'b1;

    // Longest run of denied host cycles before the host wins.
    localparam int unsigned DEFAULT_MAX_WAIT = 4;

    // Longest host burst under lock before the pipeline gets a cycle.
    localparam int unsigned LOCK_BURST = 8;

endpackage

// File: rtl/dmem_arb_rtn.sv
// Read-return tracker: remembers who issued last cycle's read and steers
// the memory read data to that requester, holding each requester's last data.
module dmem_arb_rtn
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = SIZE_DATA
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_fire_i,
    input  logic              rd_id_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              r0_rvalid_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r1_rdata_o
);

    logic              rtn_valid_q;
    logic              rtn_id_q;
    logic [DATA_W-1:0] r0_hold_q;
    logic [DATA_W-1:0] r1_hold_q;

    // Capture the pending return and the data last shown to each requester.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rtn_valid_q <= 1'b0;
            rtn_id_q    <= ARB_ID_PIPE;
            r0_hold_q   <= '0;
            r1_hold_q   <= '0;
        end else begin
            rtn_valid_q <= rd_fire_i;
            rtn_id_q    <= rd_id_i;
            r0_hold_q   <= r0_rdata_o;
            r1_hold_q   <= r1_rdata_o;
        end
    end

    // Memory data is live only in the return cycle, so pass it straight through.
    always_comb begin
        r0_rvalid_o = rtn_valid_q && (rtn_id_q == ARB_ID_PIPE);
        r1_rvalid_o = rtn_valid_q && (rtn_id_q == ARB_ID_HOST);
        r0_rdata_o  = r0_rvalid_o ? mem_rdata_i : r0_hold_q;
        r1_rdata_o  = r1_rvalid_o ? mem_rdata_i : r1_hold_q;
    end

endmodule

// File: rtl/dmem_arb.sv
// Data-memory port arbiter: pipeline has priority, host wins after MAX_WAIT
// denied cycles. Optional host burst lock under macro DMEM_ARB_LOCK_EN.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = SIZE_ADDR,
    parameter int unsigned DATA_W   = SIZE_DATA,
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_r0_req,
    input  logic              iw_r0_we,
    input  logic [ADDR_W-1:0] iw_r0_addr,
    input  logic [DATA_W-1:0] iw_r0_wdata,
    output logic              ow_r0_gnt,
    output logic              ow_r0_stall,
    output logic              or_r0_rvalid,
    output logic [DATA_W-1:0] or_r0_rdata,
    input  logic              iw_r1_req,
    input  logic              iw_r1_we,
    input  logic [ADDR_W-1:0] iw_r1_addr,
    input  logic [DATA_W-1:0] iw_r1_wdata,
    input  logic              iw_r1_lock,
    output logic              ow_r1_gnt,
    output logic              or_r1_rvalid,
    output logic [DATA_W-1:0] or_r1_rdata,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata
);

    localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       r1_win;
    logic       rd_fire;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned LockCntW = $clog2(LOCK_BURST);

    logic                lock_q, lock_d;
    logic                prio_q, prio_d;
    logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;

    // A held lock keeps the host; the cycle after a lock ends favours r0.
    assign r1_win = lock_q || !iw_r0_req || (!prio_q && (wait_cnt_q == WaitMax));
`else
    logic unused_lock;
    assign unused_lock = iw_r1_lock;
    assign r1_win      = !iw_r0_req || (wait_cnt_q == WaitMax);
`endif

    // Grants and the memory command mux; nothing is granted during reset.
    always_comb begin
        ow_r1_gnt    = !iw_rst && iw_r1_req && r1_win;
        ow_r0_gnt    = !iw_rst && iw_r0_req && !ow_r1_gnt;
        ow_r0_stall  = !iw_rst && iw_r0_req && !ow_r0_gnt;
        ow_mem_we    = ow_r1_gnt ? iw_r1_we : (ow_r0_gnt && iw_r0_we);
        ow_mem_addr  = ow_r1_gnt ? iw_r1_addr : iw_r0_addr;
        ow_mem_wdata = ow_r1_gnt ? iw_r1_wdata : iw_r0_wdata;
        rd_fire      = (ow_r0_gnt && !iw_r0_we) || (ow_r1_gnt && !iw_r1_we);
    end

    // Count consecutive denied host cycles, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!iw_r1_req || ow_r1_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock tracking: set on a locked host grant, end on release or burst limit.
    always_comb begin
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        prio_d     = 1'b0;
        if (lock_q && (!iw_r1_lock || !iw_r1_req)) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            prio_d     = 1'b1;
        end else if (ow_r1_gnt && iw_r1_lock) begin
            if (lock_cnt_q == LockCntW'(LOCK_BURST - 1)) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
                prio_d     = 1'b1;
            end else begin
                lock_d     = 1'b1;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
            prio_q     <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            prio_q     <= prio_d;
        end
    end
`endif

    dmem_arb_rtn #(
        .DATA_W (DATA_W)
    ) u_rtn (
        .clk_i       (iw_clk),
        .rst_i       (iw_rst),
        .rd_fire_i   (rd_fire),
        .rd_id_i     (ow_r1_gnt ? ARB_ID_HOST : ARB_ID_PIPE),
        .mem_rdata_i (iw_mem_rdata),
        .r0_rvalid_o (or_r0_rvalid),
        .r0_rdata_o  (or_r0_rdata),
        .r1_rvalid_o (or_r1_rvalid),
        .r1_rdata_o  (or_r1_rdata)
    );

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a synchronous 1-cycle-latency memory model.
module tb_dmem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we, r1_lock;
    logic [7:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_stall, r0_rvalid, r1_gnt, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] mem [0:255];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory model: reset preloads known words, otherwise read-first RAM.
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= 16'h1234;
            mem[8'h01] <= 16'h0A01;
            mem[8'h02] <= 16'h0B02;
            mem[8'h03] <= 16'h0C03;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    dmem_arb u_dut (
        .iw_clk       (clk),
        .iw_rst       (rst),
        .iw_r0_req    (r0_req),
        .iw_r0_we     (r0_we),
        .iw_r0_addr   (r0_addr),
        .iw_r0_wdata  (r0_wdata),
        .ow_r0_gnt    (r0_gnt),
        .ow_r0_stall  (r0_stall),
        .or_r0_rvalid (r0_rvalid),
        .or_r0_rdata  (r0_rdata),
        .iw_r1_req    (r1_req),
        .iw_r1_we     (r1_we),
        .iw_r1_addr   (r1_addr),
        .iw_r1_wdata  (r1_wdata),
        .iw_r1_lock   (r1_lock),
        .ow_r1_gnt    (r1_gnt),
        .or_r1_rvalid (r1_rvalid),
        .or_r1_rdata  (r1_rdata),
        .ow_mem_we    (mem_we),
        .ow_mem_addr  (mem_addr),
        .ow_mem_wdata (mem_wdata),
        .iw_mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;  r1_lock = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10; r0_wdata = 16'h0;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h20; r1_wdata = 16'h0;

        // Reset: requests present but everything must stay quiet.
        cyc();
        check("rst_r0_gnt", 32'(r0_gnt), 32'd0);
        check("rst_r1_gnt", 32'(r1_gnt), 32'd0);
        check("rst_stall", 32'(r0_stall), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        check("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        check("rst_r0_rdata", 32'(r0_rdata), 32'd0);
        check("rst_r1_rdata", 32'(r1_rdata), 32'd0);
        r0_req = 1'b0; r1_req = 1'b0; r1_we = 1'b0;
        cyc();
        rst = 1'b0;

        // Lone pipeline read of 0x10.
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
        samp();
        check("t1_r0_gnt", 32'(r0_gnt), 32'd1);
        check("t1_r1_gnt", 32'(r1_gnt), 32'd0);
        check("t1_stall", 32'(r0_stall), 32'd0);
        check("t1_mem_addr", 32'(mem_addr), 32'h10);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        cyc();
        r0_req = 1'b0;
        samp();
        check("t1_r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("t1_r0_rdata", 32'(r0_rdata), 32'h1234);
        check("t1_r1_rvalid", 32'(r1_rvalid), 32'd0);
        cyc();
        samp();
        check("t1_r0_rvalid_off", 32'(r0_rvalid), 32'd0);
        check("t1_r0_rdata_hold", 32'(r0_rdata), 32'h1234);

        // Contention: host wins every fifth cycle.
        cyc();
        r0_req = 1'b1; r0_addr = 8'h10;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
        for (int k = 0; k < 10; k++) begin
            samp();
            check("t2_r1_gnt", 32'(r1_gnt), 32'((k % 5) == 4));
            check("t2_r0_gnt", 32'(r0_gnt), 32'((k % 5) != 4));
            check("t2_stall", 32'(r0_stall), 32'((k % 5) == 4));
            check("t2_r1_rvalid", 32'(r1_rvalid), 32'(k > 0 && ((k - 1) % 5) == 4));
            check("t2_r0_rvalid", 32'(r0_rvalid), 32'(k > 0 && ((k - 1) % 5) != 4));
            cyc();
        end

        // Host write of 0xBEEF to 0x20, then pipeline reads it back.
        r0_req = 1'b0;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h20; r1_wdata = 16'hBEEF;
        samp();
        check("t3_r1_gnt", 32'(r1_gnt), 32'd1);
        check("t3_mem_we", 32'(mem_we), 32'd1);
        check("t3_mem_addr", 32'(mem_addr), 32'h20);
        check("t3_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        cyc();
        r1_req = 1'b0; r1_we = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h20;
        samp();
        check("t3_rd_mem_we", 32'(mem_we), 32'd0);
        check("t3_rd_r0_gnt", 32'(r0_gnt), 32'd1);
        check("t3_wr_no_rvalid", 32'(r1_rvalid), 32'd0);
        cyc();
        r0_req = 1'b0;
        samp();
        check("t3_r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("t3_r0_rdata", 32'(r0_rdata), 32'hBEEF);

        // Alternating back-to-back reads.
        cyc();
        r0_req = 1'b1; r0_addr = 8'h01;
        samp();
        check("t4_r0_gnt_a", 32'(r0_gnt), 32'd1);
        cyc();
        r0_req = 1'b0;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h02;
        samp();
        check("t4_r1_gnt", 32'(r1_gnt), 32'd1);
        check("t4_r0_rvalid_a", 32'(r0_rvalid), 32'd1);
        check("t4_r0_rdata_a", 32'(r0_rdata), 32'h0A01);
        check("t4_r1_rvalid_a", 32'(r1_rvalid), 32'd0);
        cyc();
        r1_req = 1'b0;
        r0_req = 1'b1; r0_addr = 8'h03;
        samp();
        check("t4_r0_gnt_b", 32'(r0_gnt), 32'd1);
        check("t4_r1_rvalid_b", 32'(r1_rvalid), 32'd1);
        check("t4_r1_rdata_b", 32'(r1_rdata), 32'h0B02);
        check("t4_r0_rvalid_b", 32'(r0_rvalid), 32'd0);
        check("t4_r0_rdata_hold", 32'(r0_rdata), 32'h0A01);
        cyc();
        r0_req = 1'b0;
        samp();
        check("t4_r0_rvalid_c", 32'(r0_rvalid), 32'd1);
        check("t4_r0_rdata_c", 32'(r0_rdata), 32'h0C03);
        check("t4_r1_rvalid_c", 32'(r1_rvalid), 32'd0);
        check("t4_r1_rdata_hold", 32'(r1_rdata), 32'h0B02);

        // Reset lands on the edge that would launch a host read return.
        cyc();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h02;
        samp();
        check("t5_r1_gnt", 32'(r1_gnt), 32'd1);
        @(posedge clk);
        rst = 1'b1;
        r0_req = 1'b1;
        samp();
        check("t5_r1_rvalid", 32'(r1_rvalid), 32'd0);
        check("t5_r0_rvalid", 32'(r0_rvalid), 32'd0);
        check("t5_r0_rdata", 32'(r0_rdata), 32'd0);
        check("t5_r1_rdata", 32'(r1_rdata), 32'd0);
        check("t5_gnt0", 32'(r0_gnt), 32'd0);
        check("t5_gnt1", 32'(r1_gnt), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        cyc();
        rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
        samp();
        check("t5_post_r1_rvalid", 32'(r1_rvalid), 32'd0);
        cyc();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
        samp();
        check("t5_post_gnt", 32'(r0_gnt), 32'd1);
        cyc();
        r0_req = 1'b0;
        samp();
        check("t5_post_rvalid", 32'(r0_rvalid), 32'd1);
        check("t5_post_rdata", 32'(r0_rdata), 32'h1234);

`ifdef DMEM_ARB_LOCK_EN
        // Locked host burst: granted on the fifth cycle, keeps 8, then r0 gets one.
        cyc();
        r0_req = 1'b1; r0_addr = 8'h10;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10; r1_lock = 1'b1;
        for (int k = 0; k < 13; k++) begin
            samp();
            check("t6_r1_gnt", 32'(r1_gnt), 32'(k >= 4 && k <= 11));
            check("t6_r0_gnt", 32'(r0_gnt), 32'(k < 4 || k == 12));
            cyc();
        end
        r0_req = 1'b0; r1_req = 1'b0; r1_lock = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
